// File: rtl/uart_fifo_pkg.sv
// Shared sizing helpers and types for the UART FIFO controller and its storage.
package uart_fifo_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 8;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 1 << addr_w;
    endfunction

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_flags_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register-file store: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// First-word-fall-through FIFO controller: pointers, occupancy, threshold and sticky error flags.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    input  logic              pop_ready,
    output logic [ADDR_W:0]   level,
    input  logic [ADDR_W:0]   threshold,
    output logic              above_threshold,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
);

    localparam int unsigned      PTR_W   = ptr_width(ADDR_W);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             above_q, above_d;
    err_flags_t       err_q, err_d;

    logic empty, full;
    logic push_acc, pop_acc;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                   (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

    // Acceptance looks only at start-of-cycle state, so a full FIFO cannot take a push
    // even while it is being popped, and an empty one cannot pass a push straight through.
    assign push_acc = push_valid && !full && !flush;
    assign pop_acc  = pop_ready && !empty && !flush;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        above_d = (level_q >= threshold);
        err_d   = err_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + PTR_ONE;
            if (pop_acc)  rptr_d = rptr_q + PTR_ONE;
            unique case ({push_acc, pop_acc})
                2'b10:   level_d = level_q + PTR_ONE;
                2'b01:   level_d = level_q - PTR_ONE;
                default: level_d = level_q;
            endcase
        end

        if (clear_err) begin
            err_d = '0;
        end
        // A rejected request in the same cycle as clear_err still leaves its flag set.
        if (!flush && push_valid && full) err_d.ovf = 1'b1;
        if (!flush && pop_ready && empty) err_d.udf = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            above_q <= 1'b0;
            err_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            above_q <= above_d;
            err_q   <= err_d;
        end
    end

    uart_fifo_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (push_data),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (pop_data)
    );

    assign push_ready      = !full;
    assign pop_valid       = !empty;
    assign level           = level_q;
    assign above_threshold = above_q;
    assign overflow        = err_q.ovf;
    assign underflow       = err_q.udf;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl with a queue scoreboard for popped data.
module tb_uart_fifo_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rstnn;
    logic              flush;
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              pop_ready;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   threshold;
    logic              above_threshold;
    logic              overflow;
    logic              underflow;
    logic              clear_err;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb[$];
    logic              m_ovf;
    logic              m_udf;
    logic              m_above;

    uart_fifo_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .flush           (flush),
        .push_valid      (push_valid),
        .push_data       (push_data),
        .push_ready      (push_ready),
        .pop_valid       (pop_valid),
        .pop_data        (pop_data),
        .pop_ready       (pop_ready),
        .level           (level),
        .threshold       (threshold),
        .above_threshold (above_threshold),
        .overflow        (overflow),
        .underflow       (underflow),
        .clear_err       (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " level"},      32'(level),           32'(sb.size()));
        check({tag, " pop_valid"},  32'(pop_valid),       32'(sb.size() != 0));
        check({tag, " push_ready"}, 32'(push_ready),      32'(sb.size() != DEPTH));
        check({tag, " overflow"},   32'(overflow),        32'(m_ovf));
        check({tag, " underflow"},  32'(underflow),       32'(m_udf));
        check({tag, " above_thr"},  32'(above_threshold), 32'(m_above));
    endtask

    // One clock cycle: drive inputs, compare pop_data for an accepted pop, advance the
    // model with start-of-cycle state, then compare every output after the edge.
    task automatic cycle(input string tag, input logic fl, input logic pv,
                         input logic [DATA_W-1:0] pd, input logic pr, input logic ce);
        int  lvl;
        logic pop_acc, push_acc, ovf_set, udf_set, above_n;
        flush      = fl;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        clear_err  = ce;
        lvl      = sb.size();
        above_n  = (lvl >= int'(threshold));
        pop_acc  = !fl && pr && (lvl != 0);
        push_acc = !fl && pv && (lvl != DEPTH);
        ovf_set  = !fl && pv && (lvl == DEPTH);
        udf_set  = !fl && pr && (lvl == 0);
        if (pop_acc) check({tag, " pop_data"}, 32'(pop_data), 32'(sb[0]));
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop_acc)  void'(sb.pop_front());
            if (push_acc) sb.push_back(pd);
        end
        m_ovf   = ovf_set ? 1'b1 : (ce ? 1'b0 : m_ovf);
        m_udf   = udf_set ? 1'b1 : (ce ? 1'b0 : m_udf);
        m_above = above_n;
        check_outputs(tag);
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        clear_err  = 1'b0;
    endtask

    task automatic push(input string tag, input logic [DATA_W-1:0] d);
        cycle(tag, 1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        cycle(tag, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic idle(input string tag, input logic ce);
        cycle(tag, 1'b0, 1'b0, '0, 1'b0, ce);
    endtask

    initial begin
        rstnn      = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        clear_err  = 1'b0;
        threshold  = '0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        m_above    = 1'b0;

        // Reset state, then a plain idle cycle (threshold 0 makes above_threshold rise).
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rstnn = 1'b1;
        idle("idle_after_reset", 1'b0);

        // Basic ordering.
        push("t2 push", 8'h11);
        push("t2 push", 8'h22);
        push("t2 push", 8'h33);
        repeat (3) pop("t2 pop");

        // Fill to full, reject a 17th push, clear the flag.
        for (int i = 0; i < DEPTH; i++) push("t3 fill", 8'(i * 7 + 1));
        push("t3 push_full", 8'hEE);
        idle("t3 clear_err", 1'b1);

        // Full with push+pop: pop wins, overflow set.
        cycle("t4 full_push_pop", 1'b0, 1'b1, 8'hCC, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) pop("t4 drain");
        idle("t4 clear_err", 1'b1);
        // Empty with push+pop: push wins, underflow set.
        cycle("t4 empty_push_pop", 1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
        pop("t4 pop");
        // Clear at the same time as a new rejected pop: set must win.
        cycle("t4 set_beats_clear", 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle("t4 clear_err", 1'b1);

        // Pointer wrap with back-to-back traffic.
        for (int i = 0; i < 10; i++) push("t5 fill", 8'(8'hA0 + i));
        for (int i = 0; i < 10; i++) pop("t5 pop");
        push("t5 prime", 8'h40);
        for (int i = 0; i < 20; i++) cycle("t5 b2b", 1'b0, 1'b1, 8'(8'h41 + i), 1'b1, 1'b0);
        pop("t5 last");

        // Threshold and flush.
        threshold = 5'd4;
        for (int i = 0; i < 4; i++) push("t6 thr_fill", 8'(8'h70 + i));
        idle("t6 thr_hold", 1'b0);
        threshold = 5'd17;
        for (int i = 0; i < DEPTH - 4; i++) push("t6 fill_over_thr", 8'(8'h80 + i));
        idle("t6 thr17_full", 1'b0);
        push("t6 set_ovf", 8'hFE);
        cycle("t6 flush_full_push", 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0);
        cycle("t6 flush_empty_pop", 1'b1, 1'b0, '0, 1'b1, 1'b0);
        push("t6 after_flush", 8'h9A);
        pop("t6 after_flush");

        // Asynchronous reset in the middle of a transfer.
        push("t7 pre_reset", 8'h31);
        push("t7 pre_reset", 8'h32);
        push_valid = 1'b1;
        push_data  = 8'h33;
        #2;
        rstnn = 1'b0;
        #1;
        sb.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_above = 1'b0;
        check_outputs("t7 async_reset");
        push_valid = 1'b0;
        @(posedge clk);
        #3;
        rstnn = 1'b1;
        #1;
        check_outputs("t7 after_release");
        push("t7 from_empty", 8'h5A);
        pop("t7 from_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
